// File: rtl/pe_array_pkg.sv
// pe_array_pkg: shared widths and collector FSM states for the PE array.
package pe_array_pkg;
  localparam int def_array_width = 8;
  localparam int def_mac_w = 19;
  typedef enum logic [1:0] {st_idle, st_drain, st_done} state_t;
endpackage

// File: rtl/col_fifo.sv
// col_fifo: per-column result FIFO; ports clk_i/rst_i, push/din in, pop in, dout/empty out, drop pulses on a lost push.
module col_fifo #(
  parameter int w = 19,
  parameter int depth = 8
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         push,
  input  logic [w-1:0] din,
  input  logic         pop,
  output logic [w-1:0] dout,
  output logic         empty,
  output logic         drop
);
  localparam int aw = $clog2(depth);
  logic [w-1:0] mem [depth];
  logic [aw-1:0] rp, wp;
  logic [aw:0] cnt;
  logic full, do_pop, do_push;
  assign empty = cnt == '0;
  assign full = cnt == (aw+1)'(depth);
  assign do_pop = pop && !empty;
  // a full FIFO still accepts a push when the head leaves in the same cycle
  assign do_push = push && (!full || do_pop);
  assign drop = push && !do_push;
  assign dout = mem[rp];
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      rp <= '0;
      wp <= '0;
      cnt <= '0;
    end else begin
      if (do_push) wp <= wp + aw'(1);
      if (do_pop) rp <= rp + aw'(1);
      cnt <= cnt + (aw+1)'(do_push) - (aw+1)'(do_pop);
    end
  end
  always_ff @(posedge clk_i) begin
    if (do_push) mem[wp] <= din;
  end
endmodule

// File: rtl/mac_collector.sv
// mac_collector: buffers skewed per-column MAC results and drains them row-major as frames.
// Ports: clk_i, rst_i; mac_i/mac_v_i column inputs; start_vi/rows_i frame arm; data_o/col_o/row_o/v_o with ready_i handshake; busy_o, done_o, ovf_o status.
module mac_collector
  import pe_array_pkg::*;
#(
  parameter int array_width = def_array_width,
  parameter int mac_w = def_mac_w,
  parameter int out_depth = 8,
  localparam int cw = $clog2(array_width),
  localparam int rw = $clog2(out_depth)
) (
  input  logic                                clk_i,
  input  logic                                rst_i,
  input  logic [array_width-1:0][mac_w-1:0]   mac_i,
  input  logic [array_width-1:0]              mac_v_i,
  input  logic                                start_vi,
  input  logic [rw:0]                         rows_i,
  output logic [mac_w-1:0]                    data_o,
  output logic [cw-1:0]                       col_o,
  output logic [rw-1:0]                       row_o,
  output logic                                v_o,
  input  logic                                ready_i,
  output logic                                busy_o,
  output logic                                done_o,
  output logic                                ovf_o
);
  state_t state;
  logic [cw-1:0] col;
  logic [rw-1:0] row, rows_m1, rows_c;
  logic [array_width-1:0][mac_w-1:0] head;
  logic [array_width-1:0] empty, drop, pop;
  logic xfer, last, accept;
  for (genvar j = 0; j < array_width; j++) begin : g_col
    assign pop[j] = xfer && (col == cw'(j));
    col_fifo #(.w(mac_w), .depth(out_depth)) u_fifo (
      .clk_i(clk_i), .rst_i(rst_i), .push(mac_v_i[j]), .din(mac_i[j]),
      .pop(pop[j]), .dout(head[j]), .empty(empty[j]), .drop(drop[j])
    );
  end
  assign v_o = (state == st_drain) && !empty[col];
  assign data_o = head[col];
  assign col_o = col;
  assign row_o = row;
  assign busy_o = state != st_idle;
  assign done_o = state == st_done;
  assign xfer = v_o && ready_i;
  assign last = (row == rows_m1) && (col == cw'(array_width - 1));
  assign accept = (state == st_idle) && start_vi && (rows_i != '0);
  // frame length is held as rows-1, with oversize requests clamped to the buffer depth
  assign rows_c = (rows_i > (rw+1)'(out_depth)) ? rw'(out_depth - 1) : rw'(rows_i - (rw+1)'(1));
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state <= st_idle;
      col <= '0;
      row <= '0;
      rows_m1 <= '0;
      ovf_o <= 1'b0;
    end else begin
      // a drop in the same cycle as an accepted start still raises the flag
      ovf_o <= (|drop) || (ovf_o && !accept);
      case (state)
        st_idle: if (start_vi) begin
          state <= (rows_i == '0) ? st_done : st_drain;
          rows_m1 <= rows_c;
          col <= '0;
          row <= '0;
        end
        st_drain: if (xfer) begin
          state <= last ? st_done : st_drain;
          col <= (col == cw'(array_width - 1)) ? '0 : col + cw'(1);
          row <= (col == cw'(array_width - 1)) ? row + rw'(1) : row;
        end
        default: state <= st_idle;
      endcase
    end
  end
endmodule

// File: doc/mac_collector.md
MAC_COLLECTOR -- requirements
Module: mac_collector

Interface
REQ-001 Parameter array_width, default 8, number of array columns feeding the collector.
REQ-002 Parameter mac_w, default 19, width of one MAC result.
REQ-003 Parameter out_depth, default 8, result entries buffered per column (power of two).
REQ-004 clk_i  input  1  single clock, all state on rising edge.
REQ-005 rst_i  input  1  reset, asynchronous, active-high.
REQ-006 mac_i  input  [array_width][mac_w]  per-column results from the array's bottom row.
REQ-007 mac_v_i  input  [array_width]  per-column result valid; columns arrive skewed.
REQ-008 start_vi  input  1  arm one drain frame; latches rows_i.
REQ-009 rows_i  input  clog2(out_depth)+1  rows to drain in the frame, legal 1..out_depth.
REQ-010 data_o  output  mac_w  result at the head of the selected column buffer.
REQ-011 col_o  output  clog2(array_width)  column index of data_o.
REQ-012 row_o  output  clog2(out_depth)  row index of data_o within the frame.
REQ-013 v_o  output  1  data_o valid.
REQ-014 ready_i  input  1  consumer accepts; transfer on v_o && ready_i.
REQ-015 busy_o  output  1  frame in progress.
REQ-016 done_o  output  1  one-cycle pulse after the last transfer of a frame.
REQ-017 ovf_o  output  1  sticky overflow flag.

Function
REQ-018 Each column j SHALL own a FIFO of out_depth entries; mac_v_i[j]=1 pushes mac_i[j] regardless of FSM state.
REQ-019 A pushed entry SHALL be visible at the FIFO head the cycle after the push.
REQ-020 FSM states SHALL be IDLE, DRAIN, DONE.
REQ-021 IDLE: start_vi=1 with rows_i in 1..out_depth SHALL latch rows, clear col/row counters, clear ovf_o, go to DRAIN.
REQ-022 IDLE: start_vi=1 with rows_i=0 SHALL go directly to DONE.
REQ-023 rows_i greater than out_depth SHALL be clamped to out_depth.
REQ-024 DRAIN: v_o SHALL equal "FIFO[col] non-empty"; data_o SHALL be its head; col_o/row_o SHALL be the counters.
REQ-025 A transfer SHALL pop FIFO[col]; col increments, wrapping to 0 after array_width-1 with row incrementing.
REQ-026 Output order SHALL be row-major: (row0,col0),(row0,col1)...(row0,colW-1),(row1,col0)...
REQ-027 The transfer at row=rows-1, col=array_width-1 SHALL move the FSM to DONE.
REQ-028 DONE SHALL last exactly one cycle with done_o=1, then return to IDLE.
REQ-029 v_o SHALL be 0 outside DRAIN; data_o is don't-care when v_o=0.
REQ-030 busy_o SHALL be 1 in DRAIN and DONE.
REQ-031 start_vi in DRAIN or DONE SHALL be ignored.
REQ-032 A push into a full FIFO without a same-cycle pop SHALL drop the data and set ovf_o until the next accepted start_vi.
REQ-033 Simultaneous push and pop on a full FIFO SHALL succeed with occupancy unchanged and no overflow.
REQ-034 v_o, once asserted, SHALL hold with stable data_o/col_o/row_o until the transfer.
REQ-035 Entries left unconsumed after a frame SHALL remain for the next frame.

Reset
REQ-036 Reset SHALL empty all FIFOs, clear counters, and force the FSM to IDLE.
REQ-037 During and after reset, v_o, busy_o, done_o and ovf_o SHALL be 0.
REQ-038 Reset mid-DRAIN SHALL abort the frame with no done_o pulse.

Structure
REQ-039 mac_w, array_width and the FSM state enum SHALL live in the shared pe_array_pkg.
REQ-040 The per-column buffer SHALL be one sub-module, col_fifo, instantiated array_width times.

Verification
REQ-041 Test 1: array_width=8, rows_i=2, all columns push 2 values (col j row r = 10*r+j), ready_i=1 -> 16 transfers, order 0,1..7,10..17; done_o pulses once the cycle after the 16th transfer.
REQ-042 Test 2: skewed arrival, column j pushes j cycles after column 0 -> same row-major order; v_o drops while waiting on a late column.
REQ-043 Test 3: ready_i toggles every cycle during a frame -> no loss or duplication; data_o stable while v_o && !ready_i.
REQ-044 Test 4: out_depth+1 pushes to column 3 with no drain -> ovf_o=1, first out_depth values retained; next start_vi clears ovf_o.
REQ-045 Test 5: rows_i=0 -> done_o the cycle after start_vi, no v_o; start_vi during DRAIN -> no effect.
REQ-046 Test 6: assert rst_i mid-DRAIN -> outputs 0 immediately, FIFOs empty, no done_o.
